riscv_insn_injector: RTL and testbench
======================================

RISCV_INSN_INJECTOR -- requirements
Module: riscv_insn_injector

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the instruction FIFO depth, a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have command ports: cmd_valid_i in 1, cmd_ready_o out 1, cmd_opcode_i in 7, cmd_funct3_i in 3, cmd_funct7_i in 7, cmd_rd_i in 5, cmd_rs1_i in 5, cmd_rs2_i in 5, cmd_imm_i in 32.
REQ-005 The block SHALL have cmd_err_o, out 1: one-cycle pulse when an unsupported opcode is offered.
REQ-006 The block SHALL have fetch-responder ports: instr_req_i in 1, instr_addr_i in 32, instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32.
REQ-007 The block SHALL have control/status ports: nop_fill_i in 1, flush_i in 1, count_o out $clog2(DEPTH)+1, last_addr_o out 32.

Function
REQ-008 The block SHALL encode each command by cmd_opcode_i:
- R-type: OP.
- I-type: OPIMM, LOAD, JALR.
- S-type: STORE.
- B-type: BRANCH.
- U-type: LUI, AUIPC.
- J-type: JAL.
REQ-009 Field placement SHALL follow the RV32I base formats. cmd_imm_i is already in byte-offset/final form. U-type uses cmd_imm_i[31:12]; I-type uses [11:0]; S-type uses [11:0]; B-type uses [12:1]; J-type uses [20:1]. Unused fields are ignored.
REQ-010 cmd_ready_o SHALL equal !full. There is no bypass: a pop in the same cycle does not make room for a push.
REQ-011 A push SHALL occur when cmd_valid_i & cmd_ready_o and the opcode is supported; the encoded 32-bit word is written at the tail.
REQ-012 An unsupported opcode with cmd_valid_i & cmd_ready_o SHALL be consumed, not written, and SHALL pulse cmd_err_o in the following cycle.
REQ-013 instr_gnt_o SHALL be combinational: instr_req_i & (!empty | nop_fill_i) & !flush_i.
REQ-014 On a grant with the FIFO not empty, the head word SHALL be popped.
REQ-015 On a grant with the FIFO empty, the block SHALL return NOP 0x00000013 and SHALL NOT pop.
REQ-016 instr_rvalid_o SHALL assert exactly one cycle after each grant, with instr_rdata_o holding that grant's word. Back-to-back grants yield back-to-back rvalids.
REQ-017 instr_rdata_o SHALL hold its last value while rvalid is low.
REQ-018 last_addr_o SHALL register instr_addr_i on every grant.
REQ-019 flush_i SHALL empty the FIFO at the next edge and block grants that cycle. An rvalid already scheduled from the previous cycle is still delivered. A push offered in the flush cycle is discarded; cmd_ready_o is low during flush_i.
REQ-020 count_o SHALL give FIFO occupancy 0..DEPTH. Pointers wrap modulo DEPTH. Simultaneous push and pop keeps count unchanged.

Reset
REQ-021 On rst_n low, asynchronously:
- FIFO empty, pointers 0, count_o=0;
- instr_rvalid_o=0, instr_rdata_o=0;
- last_addr_o=0;
- cmd_err_o=0.
REQ-022 Reset mid-operation SHALL discard stored words and any pending rvalid. cmd_ready_o is 1 in the first cycle after release.

Structure
REQ-023 The instruction-format enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J) and the NOP constant SHALL be added to riscv_defines; opcodes SHALL use the existing OPCODE_* constants.
REQ-024 Encoding SHALL live in one combinational sub-module, riscv_insn_encoder (opcode/fields in; word, valid out). The FIFO and responder logic SHALL stay in riscv_insn_injector.

Verification
REQ-025 Push OPIMM f3=0 rd=1 rs1=0 imm=5, then fetch -> gnt same cycle, next cycle rvalid=1 rdata=0x00500093.
REQ-026 Push OP rd=3 rs1=1 rs2=2 f3=0 f7=0; STORE f3=2 rs1=1 rs2=2 imm=8; LUI rd=5 imm=0x12345000 -> fetches return, in order, 0x002081B3, 0x0020A423, 0x123452B7.
REQ-027 Push JAL rd=1 imm=8 and BRANCH f3=0 rs1=1 rs2=2 imm=16 -> 0x008000EF, 0x00208863.
REQ-028 Fill DEPTH=4 -> count_o=4, cmd_ready_o=0. A 5th push is held. One fetch -> count_o=3 and cmd_ready_o=1 next cycle. Continuous req drains 4 words with rvalid high for 4 consecutive cycles.
REQ-029 Empty FIFO: with nop_fill_i=0, req gives no gnt. With nop_fill_i=1, gnt and rdata=0x00000013 and count stays 0. Opcode 0x7F pushed -> cmd_err_o pulse, count unchanged.
REQ-030 Three words queued, flush_i one cycle after a grant -> that grant's rvalid is still delivered, count_o=0 after the edge. Assert rst_n mid-stream -> rvalid=0 and count_o=0 immediately.

Source files
------------

// File: rtl/riscv_defines.sv
// riscv_defines: shared RV32I opcode constants, instruction-format enum and NOP word.
// Revision: 1.0
`default_nettype none

package riscv_defines;

  localparam logic [6:0] OPCODE_LOAD     = 7'h03;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPCODE_OPIMM    = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC    = 7'h17;
  localparam logic [6:0] OPCODE_STORE    = 7'h23;
  localparam logic [6:0] OPCODE_OP       = 7'h33;
  localparam logic [6:0] OPCODE_LUI      = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH   = 7'h63;
  localparam logic [6:0] OPCODE_JALR     = 7'h67;
  localparam logic [6:0] OPCODE_JAL      = 7'h6F;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'h73;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } insn_fmt_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic opcode_supported(input logic [6:0] op);
    case (op)
      OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR, OPCODE_STORE,
      OPCODE_BRANCH, OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL: opcode_supported = 1'b1;
      default:                                             opcode_supported = 1'b0;
    endcase
  endfunction

  // Unsupported opcodes map to FMT_I; callers gate the result with opcode_supported.
  function automatic insn_fmt_e opcode_fmt(input logic [6:0] op);
    case (op)
      OPCODE_OP:                  opcode_fmt = FMT_R;
      OPCODE_STORE:               opcode_fmt = FMT_S;
      OPCODE_BRANCH:              opcode_fmt = FMT_B;
      OPCODE_LUI, OPCODE_AUIPC:   opcode_fmt = FMT_U;
      OPCODE_JAL:                 opcode_fmt = FMT_J;
      default:                    opcode_fmt = FMT_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_insn_encoder.sv
// riscv_insn_encoder: combinational RV32I field-to-word encoder.
// Revision: 1.0
`default_nettype none

module riscv_insn_encoder
  import riscv_defines::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        valid
);

  always_comb begin
    word = '0;
    case (opcode_fmt(opcode))
      FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = '0;
    endcase
  end

  assign valid = opcode_supported(opcode);

endmodule

`default_nettype wire

// File: rtl/riscv_insn_injector.sv
// riscv_insn_injector: encodes commands into an instruction FIFO and serves fetches from it.
// Revision: 1.0
`default_nettype none

module riscv_insn_injector
  import riscv_defines::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [6:0]               cmd_opcode_i,
  input  logic [2:0]               cmd_funct3_i,
  input  logic [6:0]               cmd_funct7_i,
  input  logic [4:0]               cmd_rd_i,
  input  logic [4:0]               cmd_rs1_i,
  input  logic [4:0]               cmd_rs2_i,
  input  logic [31:0]              cmd_imm_i,
  output logic                     cmd_err_o,
  input  logic                     instr_req_i,
  input  logic [31:0]              instr_addr_i,
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  output logic [31:0]              instr_rdata_o,
  input  logic                     nop_fill_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              last_addr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] c_ptr_one = AW'(1);
  localparam logic [CW-1:0] c_full    = CW'(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_rvalid;
  logic [31:0]   r_rdata;
  logic [31:0]   r_last_addr;
  logic          r_cmd_err;

  logic [31:0]   w_enc_word;
  logic          w_enc_valid;
  logic          w_full;
  logic          w_empty;
  logic          w_cmd_hs;
  logic          w_push;
  logic          w_pop;
  logic          w_err;

  riscv_insn_encoder u_encoder (
    .opcode (cmd_opcode_i),
    .funct3 (cmd_funct3_i),
    .funct7 (cmd_funct7_i),
    .rd     (cmd_rd_i),
    .rs1    (cmd_rs1_i),
    .rs2    (cmd_rs2_i),
    .imm    (cmd_imm_i),
    .word   (w_enc_word),
    .valid  (w_enc_valid)
  );

  assign w_full      = (r_count == c_full);
  assign w_empty     = (r_count == '0);
  // Ready looks only at stored occupancy; a same-cycle pop never frees a slot.
  assign cmd_ready_o = !w_full && !flush_i;
  assign w_cmd_hs    = cmd_valid_i && cmd_ready_o;
  assign w_push      = w_cmd_hs && w_enc_valid;
  assign w_err       = w_cmd_hs && !w_enc_valid;
  assign instr_gnt_o = instr_req_i && (!w_empty || nop_fill_i) && !flush_i;
  assign w_pop       = instr_gnt_o && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_enc_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_last_addr <= '0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_cmd_err <= w_err;
      r_rvalid  <= instr_gnt_o;
      if (instr_gnt_o) begin
        r_rdata     <= w_empty ? NOP : r_mem[r_rd_ptr];
        r_last_addr <= instr_addr_i;
      end
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  assign count_o        = r_count;
  assign instr_rvalid_o = r_rvalid;
  assign instr_rdata_o  = r_rdata;
  assign last_addr_o    = r_last_addr;
  assign cmd_err_o      = r_cmd_err;

endmodule

`default_nettype wire

// File: tb/tb_riscv_insn_injector.sv
// tb_riscv_insn_injector: vector table, directed corner sequences and randomized model comparison.
// Revision: 1.0
`default_nettype none

module tb_riscv_insn_injector;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [6:0]  cmd_opcode_i;
  logic [2:0]  cmd_funct3_i;
  logic [6:0]  cmd_funct7_i;
  logic [4:0]  cmd_rd_i;
  logic [4:0]  cmd_rs1_i;
  logic [4:0]  cmd_rs2_i;
  logic [31:0] cmd_imm_i;
  logic        cmd_err_o;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        nop_fill_i;
  logic        flush_i;
  logic [2:0]  count_o;
  logic [31:0] last_addr_o;

  riscv_insn_injector #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_opcode_i   (cmd_opcode_i),
    .cmd_funct3_i   (cmd_funct3_i),
    .cmd_funct7_i   (cmd_funct7_i),
    .cmd_rd_i       (cmd_rd_i),
    .cmd_rs1_i      (cmd_rs1_i),
    .cmd_rs2_i      (cmd_rs2_i),
    .cmd_imm_i      (cmd_imm_i),
    .cmd_err_o      (cmd_err_o),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .nop_fill_i     (nop_fill_i),
    .flush_i        (flush_i),
    .count_o        (count_o),
    .last_addr_o    (last_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  logic [6:0] op_pool [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                               7'h37, 7'h17, 7'h6F, 7'h7F, 7'h73};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_supported(input logic [6:0] op);
    return (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h67) ||
           (op == 7'h23) || (op == 7'h63) || (op == 7'h37) || (op == 7'h17) ||
           (op == 7'h6F);
  endfunction

  // Assembles the word arithmetically from field positions of the RV32I base formats.
  function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] imm);
    logic [31:0] o, d, a, b, c, f;
    o = 32'(op); d = 32'(rd) << 7; f = 32'(f3) << 12;
    a = 32'(rs1) << 15; b = 32'(rs2) << 20; c = 32'(f7) << 25;
    case (op)
      7'h33:               return o | d | f | a | b | c;
      7'h13, 7'h03, 7'h67: return o | d | f | a | ((imm & 32'hFFF) << 20);
      7'h23:               return o | ((imm & 32'd31) << 7) | f | a | b | (((imm >> 5) & 32'd127) << 25);
      7'h63:               return o | (((imm >> 11) & 32'd1) << 7) | (((imm >> 1) & 32'd15) << 8) |
                                  f | a | b | (((imm >> 5) & 32'd63) << 25) | (((imm >> 12) & 32'd1) << 31);
      7'h37, 7'h17:        return o | d | (imm & 32'hFFFF_F000);
      7'h6F:               return o | d | (((imm >> 12) & 32'd255) << 12) | (((imm >> 11) & 32'd1) << 20) |
                                  (((imm >> 1) & 32'd1023) << 21) | (((imm >> 20) & 32'd1) << 31);
      default:             return 32'h0;
    endcase
  endfunction

  task automatic set_cmd(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    cmd_opcode_i = op; cmd_funct3_i = f3; cmd_funct7_i = f7;
    cmd_rd_i = rd; cmd_rs1_i = rs1; cmd_rs2_i = rs2; cmd_imm_i = imm;
  endtask

  task automatic push_addi(input int k);
    set_cmd(7'h13, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k));
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  // Models: FIFO contents, next registered outputs.
  logic [31:0] mq[$];
  logic        m_rvalid, m_err;
  logic [31:0] m_rdata, m_last;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,          32'h0050_0093};
    vecs[1] = '{7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,          32'h0020_81B3};
    vecs[2] = '{7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_A423};
    vecs[3] = '{7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  32'h1234_52B7};
    vecs[4] = '{7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8,          32'h0080_00EF};
    vecs[5] = '{7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd16,         32'h0020_8863};
    vecs[6] = '{7'h67, 3'd0, 7'h00, 5'd1, 5'd5, 5'd0, 32'hFFFF_FFFC,  32'hFFC2_80E7};
    vecs[7] = '{7'h17, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'h0000_1000,  32'h0000_1117};
    vecs[8] = '{7'h03, 3'd2, 7'h00, 5'd6, 5'd2, 5'd0, 32'd12,         32'h00C1_2303};

    rst_n = 1'b0; cmd_valid_i = 1'b0; instr_req_i = 1'b0; instr_addr_i = '0;
    nop_fill_i = 1'b0; flush_i = 1'b0;
    set_cmd(7'h0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick(); tick();
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_rvalid", 32'(instr_rvalid_o), 32'd0);
    chk("rst_rdata", instr_rdata_o, 32'd0);
    chk("rst_last_addr", last_addr_o, 32'd0);
    chk("rst_err", 32'(cmd_err_o), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);

    // Single-instruction encodings, each pushed then fetched.
    for (int i = 0; i < 9; i++) begin
      set_cmd(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      cmd_valid_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      chk($sformatf("vec%0d_count", i), 32'(count_o), 32'd1);
      instr_req_i = 1'b1; instr_addr_i = 32'h1000 + 32'(4 * i);
      #1;
      chk($sformatf("vec%0d_gnt", i), 32'(instr_gnt_o), 32'd1);
      tick();
      instr_req_i = 1'b0;
      chk($sformatf("vec%0d_rvalid", i), 32'(instr_rvalid_o), 32'd1);
      chk($sformatf("vec%0d_rdata", i), instr_rdata_o, vecs[i].exp);
      chk($sformatf("vec%0d_last_addr", i), last_addr_o, 32'h1000 + 32'(4 * i));
    end

    // In-order return of three queued words, back-to-back.
    for (int i = 1; i <= 3; i++) begin
      set_cmd(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      cmd_valid_i = 1'b1;
      tick();
    end
    cmd_valid_i = 1'b0;
    instr_req_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("order%0d_rvalid", i), 32'(instr_rvalid_o), 32'd1);
      chk($sformatf("order%0d_rdata", i), instr_rdata_o, vecs[i].exp);
    end
    instr_req_i = 1'b0;
    tick();
    chk("order_hold_rvalid", 32'(instr_rvalid_o), 32'd0);
    chk("order_hold_rdata", instr_rdata_o, vecs[3].exp);

    // Full FIFO: held push, one pop, refill, continuous drain.
    for (int k = 1; k <= 4; k++) push_addi(k);
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_ready", 32'(cmd_ready_o), 32'd0);
    set_cmd(7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd5);
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    chk("full_held_count", 32'(count_o), 32'd4);
    instr_req_i = 1'b1;
    tick();
    instr_req_i = 1'b0;
    chk("full_pop_count", 32'(count_o), 32'd3);
    chk("full_pop_ready", 32'(cmd_ready_o), 32'd1);
    chk("full_pop_rdata", instr_rdata_o, ref_encode(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1));
    push_addi(5);
    instr_req_i = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk($sformatf("drain%0d_rvalid", k), 32'(instr_rvalid_o), 32'd1);
      chk($sformatf("drain%0d_rdata", k), instr_rdata_o,
          ref_encode(7'h13, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k)));
    end
    #1;
    chk("drain_empty_gnt", 32'(instr_gnt_o), 32'd0);
    instr_req_i = 1'b0;
    chk("drain_count", 32'(count_o), 32'd0);

    // Empty FIFO with and without NOP fill, and unsupported opcode.
    tick();
    instr_req_i = 1'b1;
    #1;
    chk("empty_nogrant", 32'(instr_gnt_o), 32'd0);
    tick();
    chk("empty_norvalid", 32'(instr_rvalid_o), 32'd0);
    nop_fill_i = 1'b1;
    #1;
    chk("nop_gnt", 32'(instr_gnt_o), 32'd1);
    tick();
    instr_req_i = 1'b0; nop_fill_i = 1'b0;
    chk("nop_rvalid", 32'(instr_rvalid_o), 32'd1);
    chk("nop_rdata", instr_rdata_o, 32'h0000_0013);
    chk("nop_count", 32'(count_o), 32'd0);
    set_cmd(7'h7F, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd1);
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    chk("err_pulse", 32'(cmd_err_o), 32'd1);
    chk("err_count", 32'(count_o), 32'd0);
    tick();
    chk("err_clear", 32'(cmd_err_o), 32'd0);

    // Flush one cycle after a grant.
    for (int k = 6; k <= 8; k++) push_addi(k);
    instr_req_i = 1'b1;
    tick();
    flush_i = 1'b1;
    push_addi(9) ;
    flush_i = 1'b0; instr_req_i = 1'b0;
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_post_rvalid", 32'(instr_rvalid_o), 32'd0);
    chk("flush_rdata", instr_rdata_o, ref_encode(7'h13, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'd6));

    // Flush cycle comb behaviour, checked separately.
    push_addi(10);
    instr_req_i = 1'b1;
    tick();
    flush_i = 1'b1;
    #1;
    chk("flush_gnt_blocked", 32'(instr_gnt_o), 32'd0);
    chk("flush_ready_low", 32'(cmd_ready_o), 32'd0);
    chk("flush_prior_rvalid", 32'(instr_rvalid_o), 32'd1);
    tick();
    flush_i = 1'b0; instr_req_i = 1'b0;

    // Asynchronous reset mid-stream.
    push_addi(11); push_addi(12);
    instr_req_i = 1'b1;
    tick();
    instr_req_i = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rvalid", 32'(instr_rvalid_o), 32'd0);
    chk("arst_count", 32'(count_o), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("arst_ready", 32'(cmd_ready_o), 32'd1);

    // Randomized traffic against the queue model.
    m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0; m_last = '0;
    mq.delete();
    for (int n = 0; n < 400; n++) begin
      logic e_ready, e_gnt, was_empty;
      logic [31:0] w;
      cmd_valid_i  = ($urandom_range(0, 9) < 6);
      set_cmd(op_pool[$urandom_range(0, 10)], 3'($urandom), 7'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), $urandom);
      instr_req_i  = ($urandom_range(0, 9) < 6);
      instr_addr_i = $urandom;
      nop_fill_i   = ($urandom_range(0, 9) < 3);
      flush_i      = ($urandom_range(0, 19) == 0);
      was_empty = (mq.size() == 0);
      e_ready = (mq.size() < DEPTH) && !flush_i;
      e_gnt   = instr_req_i && (!was_empty || nop_fill_i) && !flush_i;
      #1;
      chk($sformatf("rnd%0d_ready", n), 32'(cmd_ready_o), 32'(e_ready));
      chk($sformatf("rnd%0d_gnt", n), 32'(instr_gnt_o), 32'(e_gnt));
      m_rvalid = e_gnt;
      if (e_gnt) begin
        m_rdata = was_empty ? 32'h0000_0013 : mq.pop_front();
        m_last  = instr_addr_i;
      end
      m_err = cmd_valid_i && e_ready && !is_supported(cmd_opcode_i);
      if (flush_i) mq.delete();
      else if (cmd_valid_i && e_ready && is_supported(cmd_opcode_i)) begin
        w = ref_encode(cmd_opcode_i, cmd_funct3_i, cmd_funct7_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i, cmd_imm_i);
        mq.push_back(w);
      end
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_rvalid", n), 32'(instr_rvalid_o), 32'(m_rvalid));
      chk($sformatf("rnd%0d_rdata", n), instr_rdata_o, m_rdata);
      chk($sformatf("rnd%0d_count", n), 32'(count_o), 32'(mq.size()));
      chk($sformatf("rnd%0d_err", n), 32'(cmd_err_o), 32'(m_err));
      chk($sformatf("rnd%0d_last", n), last_addr_o, m_last);
    end
    cmd_valid_i = 1'b0; instr_req_i = 1'b0; flush_i = 1'b0; nop_fill_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
